// File: rtl/spi_responder.sv
// rtl/spi_responder.sv - SPI mode-0 responder with a one-word tx holding register
// All SPI pins are oversampled on S_AXI_ACLK; sck is treated purely as data.
module spi_responder #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESET,
  input  logic        CS_,
  input  logic        sck,
  input  logic        sdi,
  output logic        sdo,
  input  logic [5:0]  frame_len,
  input  logic [31:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  output logic        busy,
  output logic        abort,
  output logic        underrun
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] sck_sync;
  logic [SYNC_STAGES-1:0] sdi_sync;
  logic                   cs_d;
  logic                   sck_d;
  logic [SYNC_STAGES:0]   settle;
  logic                   armed;

  logic [1:0]  state;
  logic [5:0]  bit_cnt;
  logic [5:0]  len_q;
  logic [31:0] tx_shift;
  logic [31:0] rx_shift;
  logic [31:0] tx_hold;
  logic        hold_full;

  logic        cs_s;
  logic        sck_s;
  logic        sdi_s;
  logic        cs_fall;
  logic        cs_rise;
  logic        sck_rise;
  logic        sck_fall;
  logic        start;
  logic        tx_fire;
  logic [5:0]  len_eff;
  logic [5:0]  align_amt;
  logic [31:0] tx_src;
  logic [31:0] tx_aligned;
  logic [31:0] rx_next;

  assign cs_s  = cs_sync[SYNC_STAGES-1];
  assign sck_s = sck_sync[SYNC_STAGES-1];
  assign sdi_s = sdi_sync[SYNC_STAGES-1];

  assign cs_fall  = cs_d & ~cs_s;
  assign cs_rise  = ~cs_d & cs_s;
  assign sck_rise = ~sck_d & sck_s;
  assign sck_fall = sck_d & ~sck_s;

  assign tx_ready = ~hold_full;
  assign tx_fire  = tx_valid & ~hold_full;
  assign start    = (state == S_IDLE) && cs_fall && armed;

  assign len_eff    = ((frame_len == 6'd0) || (frame_len > 6'd32)) ? 6'd32 : frame_len;
  assign align_amt  = 6'd32 - len_eff;
  assign tx_src     = hold_full ? tx_hold : 32'd0;
  // Left-align the word so the MSB of the frame always sits in bit 31.
  assign tx_aligned = tx_src << align_amt;
  assign rx_next    = {rx_shift[30:0], sdi_s};

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      cs_sync  <= '1;
      sck_sync <= '0;
      sdi_sync <= '0;
      cs_d     <= 1'b1;
      sck_d    <= 1'b0;
      settle   <= '0;
      armed    <= 1'b0;
    end else begin
      cs_sync  <= {cs_sync[SYNC_STAGES-2:0], CS_};
      sck_sync <= {sck_sync[SYNC_STAGES-2:0], sck};
      sdi_sync <= {sdi_sync[SYNC_STAGES-2:0], sdi};
      cs_d     <= cs_s;
      sck_d    <= sck_s;
      settle   <= {settle[SYNC_STAGES-1:0], 1'b1};
      // A frame may only start once CS_ has been seen high with the chain flushed,
      // so a CS_ still low from before a reset is never mistaken for a new fall.
      if (settle[SYNC_STAGES] && cs_s)
        armed <= 1'b1;
    end
  end

  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      state     <= S_IDLE;
      sdo       <= 1'b0;
      busy      <= 1'b0;
      rx_data   <= 32'd0;
      rx_valid  <= 1'b0;
      abort     <= 1'b0;
      underrun  <= 1'b0;
      bit_cnt   <= 6'd0;
      len_q     <= 6'd32;
      tx_shift  <= 32'd0;
      rx_shift  <= 32'd0;
      tx_hold   <= 32'd0;
      hold_full <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      abort    <= 1'b0;
      underrun <= 1'b0;

      if (tx_fire) begin
        tx_hold   <= tx_data;
        hold_full <= 1'b1;
      end else if (start) begin
        hold_full <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          sdo  <= 1'b0;
          busy <= 1'b0;
          if (start) begin
            state    <= S_SHIFT;
            busy     <= 1'b1;
            bit_cnt  <= 6'd0;
            len_q    <= len_eff;
            tx_shift <= tx_aligned;
            sdo      <= tx_aligned[31];
            rx_shift <= 32'd0;
            underrun <= ~hold_full;
          end
        end
        S_SHIFT: begin
          if (cs_rise) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            sdo   <= 1'b0;
            abort <= 1'b1;
          end else if (sck_rise) begin
            rx_shift <= rx_next;
            bit_cnt  <= bit_cnt + 6'd1;
            if (bit_cnt + 6'd1 == len_q) begin
              state    <= S_FLUSH;
              sdo      <= 1'b0;
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end
          end else if (sck_fall && (bit_cnt < len_q)) begin
            tx_shift <= {tx_shift[30:0], 1'b0};
            sdo      <= tx_shift[30];
          end
        end
        S_FLUSH: begin
          sdo <= 1'b0;
          if (cs_rise) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          sdo   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_responder.sv
// tb/tb_spi_responder.sv - directed-vector bench for spi_responder
module tb_spi_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs_n;
  logic        sck;
  logic        sdi;
  logic        sdo;
  logic [5:0]  frame_len;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;
  logic        abort;
  logic        underrun;

  int n_checks = 0;
  int n_errors = 0;
  int rxv_cnt  = 0;
  int abort_cnt = 0;
  int und_cnt  = 0;
  int rxv_base, abort_base, und_base;
  logic [31:0] w;

  spi_responder #(.SYNC_STAGES(2)) dut (
    .S_AXI_ACLK   (clk),
    .S_AXI_ARESET (rst),
    .CS_          (cs_n),
    .sck          (sck),
    .sdi          (sdi),
    .sdo          (sdo),
    .frame_len    (frame_len),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .busy         (busy),
    .abort        (abort),
    .underrun     (underrun)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid) rxv_cnt   <= rxv_cnt + 1;
    if (abort)    abort_cnt <= abort_cnt + 1;
    if (underrun) und_cnt   <= und_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic snap();
    rxv_base   = rxv_cnt;
    abort_base = abort_cnt;
    und_base   = und_cnt;
  endtask

  task automatic load_tx(input logic [31:0] word);
    @(posedge clk); #1;
    tx_data  = word;
    tx_valid = 1'b1;
    @(posedge clk); #1;
    tx_valid = 1'b0;
  endtask

  // Runs ncyc sck periods (4-cycle phases), capturing sdo just before each rise.
  task automatic run_frame(input int ncyc, input logic [31:0] sdi_word, input int sdi_bits,
                           input logic do_cs, input logic [5:0] len_mid,
                           input logic coincide, input logic [31:0] co_word,
                           output logic [31:0] sdo_word);
    sdo_word = 32'd0;
    @(posedge clk); #1;
    if (do_cs) cs_n = 1'b0;
    if (coincide) begin
      repeat (2) @(posedge clk);
      #1;
      tx_data  = co_word;
      tx_valid = 1'b1;
      @(posedge clk); #1;
      tx_valid = 1'b0;
      repeat (3) @(posedge clk);
    end else begin
      repeat (6) @(posedge clk);
    end
    #1;
    frame_len = len_mid;
    for (int i = 0; i < ncyc; i++) begin
      sdi = (i < sdi_bits) ? sdi_word[sdi_bits-1-i] : 1'b0;
      repeat (4) @(posedge clk);
      #1;
      sdo_word = {sdo_word[30:0], sdo};
      sck = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      sck = 1'b0;
    end
    repeat (6) @(posedge clk);
    #1;
    sdi = 1'b0;
  endtask

  task automatic end_frame();
    @(posedge clk); #1;
    cs_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; cs_n = 1'b1; sck = 1'b0; sdi = 1'b0;
    frame_len = 6'd16; tx_data = 32'd0; tx_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rst_sdo",      {31'd0, sdo},      32'd0);
    check("rst_busy",     {31'd0, busy},     32'd0);
    check("rst_rx_data",  rx_data,           32'd0);
    check("rst_flags",    {29'd0, rx_valid, abort, underrun}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (8) @(posedge clk);

    // Loopback; frame_len changed mid-frame must not matter
    snap();
    frame_len = 6'd16;
    load_tx(32'h0000A5C3);
    check("lb_tx_ready_full", {31'd0, tx_ready}, 32'd0);
    run_frame(16, 32'h3C5A, 16, 1'b1, 6'd3, 1'b0, 32'd0, w);
    check("lb_sdo",      w,       32'h0000A5C3);
    check("lb_rx_data",  rx_data, 32'h00003C5A);
    check("lb_rx_valid", rxv_cnt - rxv_base,   1);
    check("lb_abort",    abort_cnt - abort_base, 0);
    check("lb_underrun", und_cnt - und_base,   0);
    check("lb_busy_flush", {31'd0, busy},     32'd1);
    check("lb_tx_ready_empty", {31'd0, tx_ready}, 32'd1);
    end_frame();
    check("lb_busy_idle", {31'd0, busy}, 32'd0);

    // Full width via frame_len=0
    snap();
    frame_len = 6'd0;
    load_tx(32'hDEADBEEF);
    run_frame(32, 32'h12345678, 32, 1'b1, 6'd0, 1'b0, 32'd0, w);
    check("fw_sdo",      w,       32'hDEADBEEF);
    check("fw_rx_data",  rx_data, 32'h12345678);
    check("fw_rx_valid", rxv_cnt - rxv_base, 1);
    end_frame();

    // Early CS_ release
    snap();
    frame_len = 6'd12;
    load_tx(32'h00000FF0);
    run_frame(5, 32'h00000ABC, 12, 1'b1, 6'd12, 1'b0, 32'd0, w);
    end_frame();
    check("er_abort",    abort_cnt - abort_base, 1);
    check("er_rx_valid", rxv_cnt - rxv_base,     0);
    check("er_rx_data",  rx_data,                32'h12345678);
    check("er_busy",     {31'd0, busy},          32'd0);

    // Underrun, extra clocks, and a tx load coinciding with the CS_ fall
    snap();
    frame_len = 6'd8;
    run_frame(10, 32'h000002D3, 10, 1'b1, 6'd8, 1'b1, 32'h0000000A, w);
    check("ur_underrun", und_cnt - und_base,  1);
    check("ur_sdo_zero", w,                   32'd0);
    check("ur_rx_data",  rx_data,             32'h000000B4);
    check("ur_rx_valid", rxv_cnt - rxv_base,  1);
    check("ur_next_loaded", {31'd0, tx_ready}, 32'd0);
    end_frame();

    snap();
    frame_len = 6'd4;
    run_frame(4, 32'h9, 4, 1'b1, 6'd4, 1'b0, 32'd0, w);
    check("co_sdo",      w,                 32'h0000000A);
    check("co_rx_data",  rx_data,           32'h00000009);
    check("co_underrun", und_cnt - und_base, 0);
    end_frame();

    // Reset mid-frame with CS_ held low
    snap();
    frame_len = 6'd16;
    load_tx(32'h0000BEEF);
    run_frame(3, 32'h5, 3, 1'b1, 6'd16, 1'b0, 32'd0, w);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run_frame(8, 32'hFF, 8, 1'b0, 6'd16, 1'b0, 32'd0, w);
    check("rm_rx_valid", rxv_cnt - rxv_base, 0);
    check("rm_busy",     {31'd0, busy},      32'd0);
    check("rm_rx_data",  rx_data,            32'd0);
    check("rm_sdo",      w,                  32'd0);
    end_frame();
    check("rm_abort",    abort_cnt - abort_base, 0);
    check("rm_underrun", und_cnt - und_base,     0);

    snap();
    load_tx(32'h00001234);
    run_frame(16, 32'hC0DE, 16, 1'b1, 6'd16, 1'b0, 32'd0, w);
    check("rr_sdo",      w,                 32'h00001234);
    check("rr_rx_data",  rx_data,           32'h0000C0DE);
    check("rr_rx_valid", rxv_cnt - rxv_base, 1);
    end_frame();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
